// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: resolves branches/jumps into a combinational PC redirect,
// registers the EX/MEM fields under stall/flush control and counts taken transfers.
module ex_mem_stage #(
   parameter int unsigned     XLEN          = 32,
   parameter logic [XLEN-1:0] RESET_PC_LINK = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] alu_result,
   input  logic            zero,
   input  logic            blt,
   input  logic            bge,
   input  logic            bltu,
   input  logic            bgeu,
   input  logic [XLEN-1:0] pc_ex,
   input  logic [XLEN-1:0] imm_ex,
   input  logic            is_branch,
   input  logic            is_jal,
   input  logic            is_jalr,
   input  logic [2:0]      funct3_ex,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_ex,
   input  logic            reg_write_ex,
   input  logic            mem_read_ex,
   input  logic            mem_write_ex,
   input  logic            mem_to_reg_ex,
   input  logic            stall_i,
   input  logic            flush_i,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic            mem_valid,
   output logic [XLEN-1:0] mem_result,
   output logic [XLEN-1:0] mem_store_data,
   output logic [4:0]      mem_rd,
   output logic [2:0]      mem_funct3,
   output logic            mem_reg_write,
   output logic            mem_mem_read,
   output logic            mem_mem_write,
   output logic            mem_mem_to_reg,
   output logic            mem_misaligned,
   output logic [31:0]     taken_cnt
);

   logic            cond;
   logic            taken;
   logic            misalign;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] result;

   logic            valid_q, valid_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [XLEN-1:0] sdata_q, sdata_d;
   logic [4:0]      rd_q, rd_d;
   logic [2:0]      funct3_q, funct3_d;
   logic            rw_q, rw_d;
   logic            mr_q, mr_d;
   logic            mw_q, mw_d;
   logic            m2r_q, m2r_d;
   logic            mis_q, mis_d;
   logic [31:0]     cnt_q, cnt_d;

   always_comb begin
      cond = 1'b0;
      case (funct3_ex)
         3'b000:  cond = zero;
         3'b001:  cond = ~zero;
         3'b100:  cond = blt;
         3'b101:  cond = bge;
         3'b110:  cond = bltu;
         3'b111:  cond = bgeu;
         default: cond = 1'b0;
      endcase
      taken    = (is_branch & cond) | is_jal | is_jalr;
      target   = is_jalr ? {alu_result[XLEN-1:1], 1'b0} : pc_ex + imm_ex;
      misalign = taken & target[1];
      // Jumps write the link address; everything else forwards the ALU result.
      result   = (is_jal | is_jalr) ? pc_ex + XLEN'(4) : alu_result;
   end

   assign redirect    = ex_valid & taken & ~misalign & ~stall_i & rst_n;
   assign redirect_pc = target;

   always_comb begin
      valid_d  = valid_q;
      result_d = result_q;
      sdata_d  = sdata_q;
      rd_d     = rd_q;
      funct3_d = funct3_q;
      rw_d     = rw_q;
      mr_d     = mr_q;
      mw_d     = mw_q;
      m2r_d    = m2r_q;
      mis_d    = mis_q;
      cnt_d    = cnt_q;
      if (!stall_i) begin
         if (flush_i) begin
            valid_d = 1'b0;
            rw_d    = 1'b0;
            mr_d    = 1'b0;
            mw_d    = 1'b0;
            m2r_d   = 1'b0;
            mis_d   = 1'b0;
         end else begin
            valid_d  = ex_valid;
            result_d = result;
            sdata_d  = rs2_data;
            rd_d     = rd_ex;
            funct3_d = funct3_ex;
            // A misaligned transfer travels on as a trap with no side effects.
            rw_d     = ex_valid & reg_write_ex & ~misalign;
            mr_d     = ex_valid & mem_read_ex & ~misalign;
            mw_d     = ex_valid & mem_write_ex & ~misalign;
            m2r_d    = ex_valid & mem_to_reg_ex;
            mis_d    = ex_valid & misalign;
            cnt_d    = cnt_q + 32'(ex_valid & taken & ~misalign);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         result_q <= RESET_PC_LINK;
         sdata_q  <= RESET_PC_LINK;
         rd_q     <= '0;
         funct3_q <= '0;
         rw_q     <= 1'b0;
         mr_q     <= 1'b0;
         mw_q     <= 1'b0;
         m2r_q    <= 1'b0;
         mis_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         result_q <= result_d;
         sdata_q  <= sdata_d;
         rd_q     <= rd_d;
         funct3_q <= funct3_d;
         rw_q     <= rw_d;
         mr_q     <= mr_d;
         mw_q     <= mw_d;
         m2r_q    <= m2r_d;
         mis_q    <= mis_d;
         cnt_q    <= cnt_d;
      end
   end

   assign mem_valid      = valid_q;
   assign mem_result     = result_q;
   assign mem_store_data = sdata_q;
   assign mem_rd         = rd_q;
   assign mem_funct3     = funct3_q;
   assign mem_reg_write  = rw_q;
   assign mem_mem_read   = mr_q;
   assign mem_mem_write  = mw_q;
   assign mem_mem_to_reg = m2r_q;
   assign mem_misaligned = mis_q;
   assign taken_cnt      = cnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed cases with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_ex_mem_stage;

   logic        clk, rst_n;
   logic        ex_valid, zero, blt, bge, bltu, bgeu;
   logic [31:0] alu_result, pc_ex, imm_ex, rs2_data;
   logic        is_branch, is_jal, is_jalr;
   logic [2:0]  funct3_ex;
   logic [4:0]  rd_ex;
   logic        reg_write_ex, mem_read_ex, mem_write_ex, mem_to_reg_ex;
   logic        stall_i, flush_i;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
   logic        mem_misaligned;
   logic [31:0] mem_result, mem_store_data, taken_cnt;
   logic [4:0]  mem_rd;
   logic [2:0]  mem_funct3;

   ex_mem_stage dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_result(alu_result),
      .zero(zero), .blt(blt), .bge(bge), .bltu(bltu), .bgeu(bgeu),
      .pc_ex(pc_ex), .imm_ex(imm_ex), .is_branch(is_branch), .is_jal(is_jal),
      .is_jalr(is_jalr), .funct3_ex(funct3_ex), .rs2_data(rs2_data), .rd_ex(rd_ex),
      .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex),
      .mem_write_ex(mem_write_ex), .mem_to_reg_ex(mem_to_reg_ex),
      .stall_i(stall_i), .flush_i(flush_i), .redirect(redirect),
      .redirect_pc(redirect_pc), .mem_valid(mem_valid), .mem_result(mem_result),
      .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_funct3(mem_funct3),
      .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
      .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
      .mem_misaligned(mem_misaligned), .taken_cnt(taken_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 0;

   // Model of the registered EX/MEM contents
   bit          m_valid, m_rw, m_mr, m_mw, m_m2r, m_mis, m_data_known;
   logic [31:0] m_result, m_sdata, m_cnt;
   logic [4:0]  m_rd;
   logic [2:0]  m_f3;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit f_taken();
      if (is_branch) begin
         case (funct3_ex)
            3'd0: return zero == 1'b1;
            3'd1: return zero == 1'b0;
            3'd4: return blt == 1'b1;
            3'd5: return bge == 1'b1;
            3'd6: return bltu == 1'b1;
            3'd7: return bgeu == 1'b1;
            default: return 1'b0;
         endcase
      end
      return (is_jal || is_jalr);
   endfunction

   function automatic logic [31:0] f_target();
      if (is_jalr) return alu_result & 32'hFFFF_FFFE;
      return pc_ex + imm_ex;
   endfunction

   function automatic bit f_mis();
      logic [31:0] t;
      t = f_target();
      return f_taken() && (t[1] == 1'b1);
   endfunction

   task automatic model_reset();
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_mis = 0;
      m_result = 0; m_sdata = 0; m_rd = 0; m_f3 = 0; m_cnt = 0; m_data_known = 1;
   endtask

   task automatic model_update();
      bit ok;
      if (stall_i) return;
      if (flush_i) begin
         m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_mis = 0;
         m_data_known = 0;
         return;
      end
      ok = ex_valid && !f_mis();
      m_valid  = ex_valid;
      m_result = (is_jal || is_jalr) ? pc_ex + 32'd4 : alu_result;
      m_sdata  = rs2_data;
      m_rd     = rd_ex;
      m_f3     = funct3_ex;
      m_rw     = ok && reg_write_ex;
      m_mr     = ok && mem_read_ex;
      m_mw     = ok && mem_write_ex;
      m_m2r    = ex_valid && mem_to_reg_ex;
      m_mis    = ex_valid && f_mis();
      m_data_known = 1;
      if (ok && f_taken()) m_cnt = m_cnt + 1;
   endtask

   // Advance to just after the next rising edge, updating the model with the sampled inputs.
   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_update();
      #1;
   endtask

   task automatic idle();
      ex_valid = 0; alu_result = 0; zero = 0; blt = 0; bge = 0; bltu = 0; bgeu = 0;
      pc_ex = 0; imm_ex = 0; is_branch = 0; is_jal = 0; is_jalr = 0; funct3_ex = 0;
      rs2_data = 0; rd_ex = 0; reg_write_ex = 0; mem_read_ex = 0; mem_write_ex = 0;
      mem_to_reg_ex = 0; stall_i = 0; flush_i = 0;
   endtask

   task automatic rand_inputs();
      int cls;
      idle();
      ex_valid   = ($urandom % 4) != 0;
      cls        = $urandom % 4;
      is_branch  = (cls == 1);
      is_jal     = (cls == 2);
      is_jalr    = (cls == 3);
      funct3_ex  = 3'($urandom);
      {zero, blt, bge, bltu, bgeu} = 5'($urandom);
      alu_result = $urandom;
      pc_ex      = ($urandom % 2) ? 32'hFFFF_FF00 + ($urandom % 256) : $urandom;
      pc_ex[1:0] = 2'b00;
      imm_ex     = ($urandom % 2) ? 32'($signed(12'($urandom))) : $urandom;
      rs2_data   = $urandom;
      rd_ex      = 5'($urandom);
      {reg_write_ex, mem_read_ex, mem_write_ex, mem_to_reg_ex} = 4'($urandom);
      stall_i    = ($urandom % 5) == 0;
      flush_i    = ($urandom % 6) == 0;
   endtask

   // Single compare process: checks combinational and registered outputs every cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         if (!rst_n) chk("redirect_in_reset", 32'(redirect), 0);
         else begin
            chk("redirect", 32'(redirect),
                32'(ex_valid && f_taken() && !f_mis() && !stall_i));
            if (ex_valid && f_taken() && !f_mis() && !stall_i)
               chk("redirect_pc", redirect_pc, f_target());
         end
         chk("mem_valid", 32'(mem_valid), 32'(m_valid));
         chk("mem_reg_write", 32'(mem_reg_write), 32'(m_rw));
         chk("mem_mem_read", 32'(mem_mem_read), 32'(m_mr));
         chk("mem_mem_write", 32'(mem_mem_write), 32'(m_mw));
         chk("mem_mem_to_reg", 32'(mem_mem_to_reg), 32'(m_m2r));
         chk("mem_misaligned", 32'(mem_misaligned), 32'(m_mis));
         chk("taken_cnt", taken_cnt, m_cnt);
         if (m_data_known) begin
            chk("mem_result", mem_result, m_result);
            chk("mem_store_data", mem_store_data, m_sdata);
            chk("mem_rd", 32'(mem_rd), 32'(m_rd));
            chk("mem_funct3", 32'(mem_funct3), 32'(m_f3));
         end
      end
   end

   initial begin
      idle();
      rst_n = 1;
      model_reset();
      #2 rst_n = 0;
      chk_en = 1;
      repeat (2) cycle();
      rst_n = 1;
      // Reset release with no valid instructions
      repeat (3) begin
         cycle();
         @(negedge clk);
         chk("idle_valid", 32'(mem_valid), 0);
         chk("idle_cnt", taken_cnt, 0);
      end

      // Taken beq
      cycle();
      ex_valid = 1; is_branch = 1; funct3_ex = 3'b000; zero = 1;
      pc_ex = 32'h100; imm_ex = 32'h20;
      @(negedge clk);
      chk("beq_redirect", 32'(redirect), 1);
      chk("beq_target", redirect_pc, 32'h120);
      cycle();
      zero = 0;
      @(negedge clk);
      chk("beq_cnt", taken_cnt, 1);
      chk("beq_nt_redirect", 32'(redirect), 0);
      cycle();
      idle();
      @(negedge clk);
      chk("beq_nt_cnt", taken_cnt, 1);

      // jalr with odd target
      cycle();
      ex_valid = 1; is_jalr = 1; alu_result = 32'h2001; pc_ex = 32'h400;
      rd_ex = 5; reg_write_ex = 1;
      @(negedge clk);
      chk("jalr_target", redirect_pc, 32'h2000);
      cycle();
      idle();
      @(negedge clk);
      chk("jalr_link", mem_result, 32'h404);
      chk("jalr_rd", 32'(mem_rd), 5);
      chk("jalr_rw", 32'(mem_reg_write), 1);
      chk("jalr_cnt", taken_cnt, 2);

      // Misaligned jal
      cycle();
      ex_valid = 1; is_jal = 1; pc_ex = 0; imm_ex = 32'h6; reg_write_ex = 1;
      @(negedge clk);
      chk("mis_redirect", 32'(redirect), 0);
      cycle();
      idle();
      @(negedge clk);
      chk("mis_flag", 32'(mem_misaligned), 1);
      chk("mis_valid", 32'(mem_valid), 1);
      chk("mis_rw", 32'(mem_reg_write), 0);
      chk("mis_cnt", taken_cnt, 2);

      // Stall overrides flush, then flush alone
      cycle();
      ex_valid = 1; alu_result = 32'h55; rd_ex = 3; reg_write_ex = 1;
      cycle();
      idle();
      ex_valid = 1; is_branch = 1; zero = 1; pc_ex = 32'h200; imm_ex = 32'h10;
      stall_i = 1; flush_i = 1;
      @(negedge clk);
      chk("stall_redirect", 32'(redirect), 0);
      chk("stall_result0", mem_result, 32'h55);
      cycle();
      @(negedge clk);
      chk("stall_result1", mem_result, 32'h55);
      chk("stall_rd", 32'(mem_rd), 3);
      cycle();
      stall_i = 0;
      cycle();
      idle();
      @(negedge clk);
      chk("flush_valid", 32'(mem_valid), 0);
      chk("flush_cnt", taken_cnt, 2);

      // Address wrap on jal
      cycle();
      ex_valid = 1; is_jal = 1; pc_ex = 32'hFFFF_FFFC; imm_ex = 32'h8; reg_write_ex = 1;
      @(negedge clk);
      chk("wrap_target", redirect_pc, 32'h4);
      cycle();
      idle();
      @(negedge clk);
      chk("wrap_link", mem_result, 32'h0);
      chk("wrap_cnt3", taken_cnt, 3);

      // Counter wrap: preload through a stalled cycle, then one taken jump
      cycle();
      idle();
      stall_i = 1;
      force dut.cnt_q = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
      cycle();
      release dut.cnt_q;
      idle();
      ex_valid = 1; is_jal = 1; pc_ex = 32'h10; imm_ex = 32'h10;
      @(negedge clk);
      chk("pre_wrap_cnt", taken_cnt, 32'hFFFF_FFFF);
      cycle();
      idle();
      @(negedge clk);
      chk("cnt_wrap", taken_cnt, 0);

      // Randomized traffic with a mid-run reset
      repeat (300) begin
         cycle();
         rand_inputs();
      end
      cycle();
      #1 rst_n = 0;
      model_reset();
      rand_inputs();
      @(negedge clk);
      chk("midrst_valid", 32'(mem_valid), 0);
      chk("midrst_cnt", taken_cnt, 0);
      cycle();
      rst_n = 1;
      repeat (300) begin
         cycle();
         rand_inputs();
      end
      cycle();
      idle();
      @(negedge clk);
      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute-to-memory boundary of the five-stage RV32I pipeline. Sits directly downstream of the ALU.
- Consumes the ALU result and branch flags, resolves conditional branches and jumps, and raises a PC redirect.
- Registers the EX/MEM pipeline fields with stall/flush control and keeps a taken-branch counter.

Parameters:
- XLEN, 32, datapath width (only 32 supported)
- RESET_PC_LINK, 0, reset value of registered data fields

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX holds a real instruction
- alu_result  in  32  ALU f_out
- zero, blt, bge, bltu, bgeu  in  1 each  ALU compare flags
- pc_ex  in  32  PC of EX instruction
- imm_ex  in  32  sign-extended immediate
- is_branch, is_jal, is_jalr  in  1 each  control-flow class (one-hot or none)
- funct3_ex  in  3  branch condition / memory size
- rs2_data  in  32  forwarded store data
- rd_ex  in  5  destination register
- reg_write_ex, mem_read_ex, mem_write_ex, mem_to_reg_ex  in  1 each  control
- stall_i  in  1  hold EX/MEM register (from hazard unit)
- flush_i  in  1  load bubble into EX/MEM register
- redirect  out  1  combinational: fetch must take redirect_pc; upstream flushes IF/ID, ID/EX
- redirect_pc  out  32  combinational target
- mem_valid, mem_result, mem_store_data, mem_rd, mem_funct3, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_misaligned  out  registered EX/MEM fields (widths as inputs; misaligned 1)
- taken_cnt  out  32  taken-transfer counter

Behaviour:
- Reset (rst_n low, asynchronous): mem_valid=0, all mem_* controls=0, mem_result/mem_store_data=RESET_PC_LINK, mem_rd=0, mem_funct3=0, taken_cnt=0. redirect=0 while in reset.
- Condition taken, when is_branch, by funct3_ex:
  - 000 zero; 001 !zero; 100 blt; 101 bge; 110 bltu; 111 bgeu; 010/011 never taken.
  - jal and jalr are always taken.
- Target:
  - branch and jal: pc_ex+imm_ex, modulo 2^32 (wraps).
  - jalr: alu_result with bit0 cleared (ALU computes rs1+imm).
- misalign = taken & target[1].
- redirect = ex_valid & taken & ~misalign & ~stall_i & rst_n. redirect_pc = target whenever redirect=1; otherwise don't-care (drive target).
- Result mux: jal/jalr write pc_ex+4 (wraps) to mem_result; all others write alu_result.
- Register update, priority order:
  - stall_i=1: hold all fields and taken_cnt; flush_i is ignored that cycle (hazard unit holds flush until stall drops).
  - else flush_i=1: mem_valid=0 and all control outputs =0; data fields don't-care.
  - else: load all fields. mem_valid=ex_valid. Controls are gated by ex_valid (bubble when 0).
- Misaligned transfer: mem_misaligned=1; mem_reg_write, mem_mem_read, mem_mem_write forced 0; mem_valid=1 so the trap is reported downstream. No redirect.
- taken_cnt increments by 1 on each non-stalled, non-flushed cycle with ex_valid & taken & ~misalign. Wraps 0xFFFFFFFF->0.
- Latency: redirect is 0-cycle combinational. EX/MEM fields are visible 1 cycle after capture.
- Reset mid-operation clears everything immediately; the next capture follows normal rules after rst_n rises.

Test Plan:
- Reset release, ex_valid=0 for 3 cycles -> mem_valid=0, controls 0, taken_cnt=0, redirect never 1.
- Branch: pc_ex=0x100, imm=0x20, is_branch, funct3=000, zero=1 -> redirect=1, redirect_pc=0x120, taken_cnt=1. Repeat with zero=0 -> redirect=0, cnt unchanged.
- jalr: alu_result=0x2001, pc_ex=0x400, rd=5 -> redirect_pc=0x2000; next cycle mem_result=0x404, mem_rd=5, mem_reg_write=1.
- Misaligned: jal pc_ex=0x0, imm=0x6 -> redirect=0; next cycle mem_misaligned=1, mem_valid=1, mem_reg_write=0, cnt unchanged.
- Stall then flush: load add (alu_result=0x55, rd=3); then stall_i=1 and flush_i=1 together with a taken beq in EX:
  - -> redirect=0 and fields hold 0x55/rd=3 while stalled.
  - Drop stall keeping flush -> mem_valid=0 next cycle, taken_cnt unchanged.
- Wrap: pc_ex=0xFFFFFFFC, jal imm=8 -> redirect_pc=0x4, mem_result=0x0. Force 2^32 taken transfers (or preload via backdoor to 0xFFFFFFFF) -> taken_cnt wraps to 0.
